// File: rtl/bresenham_line_engine.sv
// Bresenham line rasteriser: one captured segment in, one pixel write per accepted cycle out.
// Optional BLA_PIXEL_READY_EN adds a pix_ready handshake that stalls the walk.
module bresenham_line_engine #(
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               draw_en,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
`ifdef BLA_PIXEL_READY_EN
  input  logic               pix_ready,
`endif
  output logic               pix_wr,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               busy,
  output logic               draw_done
);

  localparam int DW = COORD_W + 1;
  localparam int EW = COORD_W + 3;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAW = 2'd2, DONE = 2'd3} state_t;

  state_t                state_r, next_state_s;
  logic [COORD_W-1:0]    x0_r, y0_r, x1_r, y1_r;
  logic [COORD_W-1:0]    cur_x_r, cur_y_r;
  logic signed [DW-1:0]  dx_r, dy_r;
  logic signed [EW-1:0]  err_r;
  logic                  sx_neg_r, sy_neg_r;

  logic [DW-1:0]         adx_s, ady_s;
  logic signed [EW-1:0]  err_load_s, dx_ext_s, dy_ext_s, e2_s, err_next_s;
  logic                  step_x_s, step_y_s, at_end_s, accept_s;
  logic [COORD_W-1:0]    cur_x_next_s, cur_y_next_s;

`ifdef BLA_PIXEL_READY_EN
  assign accept_s = pix_ready;
`else
  assign accept_s = 1'b1;
`endif

  assign at_end_s = (cur_x_r == x1_r) && (cur_y_r == y1_r);
  assign pix_x    = cur_x_r;
  assign pix_y    = cur_y_r;

  // Next-state decode; a dropped draw_en aborts from any non-idle state.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (draw_en) next_state_s = LOAD;
        else         next_state_s = IDLE;
      end
      LOAD: begin
        if (draw_en) next_state_s = DRAW;
        else         next_state_s = IDLE;
      end
      DRAW: begin
        if (!draw_en)                 next_state_s = IDLE;
        else if (at_end_s && accept_s) next_state_s = DONE;
        else                          next_state_s = DRAW;
      end
      DONE: begin
        if (draw_en) next_state_s = DONE;
        else         next_state_s = IDLE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Segment setup terms and one Bresenham step; both axis tests share the same e2.
  always_comb begin
    adx_s = {DW{1'b0}};
    ady_s = {DW{1'b0}};
    if (x1_r >= x0_r) adx_s = {1'b0, x1_r} - {1'b0, x0_r};
    else              adx_s = {1'b0, x0_r} - {1'b0, x1_r};
    if (y1_r >= y0_r) ady_s = {1'b0, y1_r} - {1'b0, y0_r};
    else              ady_s = {1'b0, y0_r} - {1'b0, y1_r};
    err_load_s = $signed({2'b00, adx_s}) - $signed({2'b00, ady_s});

    dx_ext_s = {{(EW-DW){dx_r[DW-1]}}, dx_r};
    dy_ext_s = {{(EW-DW){dy_r[DW-1]}}, dy_r};
    e2_s     = {err_r[EW-2:0], 1'b0};
    step_x_s = (e2_s >= dy_ext_s);
    step_y_s = (e2_s <= dx_ext_s);

    err_next_s = err_r;
    if (step_x_s) err_next_s = err_next_s + dy_ext_s;
    else          err_next_s = err_next_s;
    if (step_y_s) err_next_s = err_next_s + dx_ext_s;
    else          err_next_s = err_next_s;

    cur_x_next_s = cur_x_r;
    cur_y_next_s = cur_y_r;
    if (step_x_s) cur_x_next_s = sx_neg_r ? (cur_x_r - COORD_W'(1)) : (cur_x_r + COORD_W'(1));
    else          cur_x_next_s = cur_x_r;
    if (step_y_s) cur_y_next_s = sy_neg_r ? (cur_y_r - COORD_W'(1)) : (cur_y_r + COORD_W'(1));
    else          cur_y_next_s = cur_y_r;
  end

  // State register and status outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r   <= IDLE;
      pix_wr    <= 1'b0;
      busy      <= 1'b0;
      draw_done <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      pix_wr    <= (next_state_s == DRAW);
      busy      <= (next_state_s == LOAD) || (next_state_s == DRAW);
      draw_done <= (next_state_s == DONE);
    end
  end

  // Endpoint capture, setup, and the walk itself; cur only moves on an accepted pixel.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x0_r     <= {COORD_W{1'b0}};
      y0_r     <= {COORD_W{1'b0}};
      x1_r     <= {COORD_W{1'b0}};
      y1_r     <= {COORD_W{1'b0}};
      cur_x_r  <= {COORD_W{1'b0}};
      cur_y_r  <= {COORD_W{1'b0}};
      dx_r     <= {DW{1'b0}};
      dy_r     <= {DW{1'b0}};
      err_r    <= {EW{1'b0}};
      sx_neg_r <= 1'b0;
      sy_neg_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (draw_en) begin
            x0_r <= x0;
            y0_r <= y0;
            x1_r <= x1;
            y1_r <= y1;
          end
        end
        LOAD: begin
          dx_r     <= $signed(adx_s);
          dy_r     <= -$signed(ady_s);
          err_r    <= err_load_s;
          sx_neg_r <= (x1_r < x0_r);
          sy_neg_r <= (y1_r < y0_r);
          cur_x_r  <= x0_r;
          cur_y_r  <= y0_r;
        end
        DRAW: begin
          if (accept_s && !at_end_s) begin
            err_r   <= err_next_s;
            cur_x_r <= cur_x_next_s;
            cur_y_r <= cur_y_next_s;
          end
        end
        default: begin
          err_r <= err_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Directed table-driven bench for bresenham_line_engine, plus abort, reset and
// (with BLA_PIXEL_READY_EN) stall sequences.
module tb_bresenham_line_engine;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       draw_en = 1'b0;
  logic [7:0] x0 = 8'd0, y0 = 8'd0, x1 = 8'd0, y1 = 8'd0;
  logic       pix_wr, busy, draw_done;
  logic [7:0] pix_x, pix_y;
`ifdef BLA_PIXEL_READY_EN
  logic       pix_ready = 1'b1;
`endif

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  bresenham_line_engine #(.COORD_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .draw_en(draw_en),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
`ifdef BLA_PIXEL_READY_EN
    .pix_ready(pix_ready),
`endif
    .pix_wr(pix_wr), .pix_x(pix_x), .pix_y(pix_y),
    .busy(busy), .draw_done(draw_done)
  );

  // Expected pixel i lives in byte i of ex/ey; n > 8 means the x=i, y=255-i diagonal.
  typedef struct {
    logic [7:0]  x0, y0, x1, y1;
    int          n;
    logic [63:0] ex, ey;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int npix, first_cyc, last_cyc, done_cyc, busy_cyc;
    logic [7:0] ex, ey;
    npix = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; busy_cyc = 0;
    @(negedge clk);
    x0 = v.x0; y0 = v.y0; x1 = v.x1; y1 = v.y1;
    draw_en = 1'b1;
    for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        x0 = 8'hA5; y0 = 8'h5A; x1 = 8'h11; y1 = 8'hEE;
      end
      if (busy) busy_cyc++;
      if (pix_wr) begin
        if (npix < v.n) begin
          if (v.n > 8) begin
            ex = npix[7:0];
            ey = 8'd255 - npix[7:0];
          end else begin
            ex = v.ex[8*npix +: 8];
            ey = v.ey[8*npix +: 8];
          end
          check($sformatf("v%0d pix%0d x", idx, npix), pix_x, ex);
          check($sformatf("v%0d pix%0d y", idx, npix), pix_y, ey);
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        npix++;
      end
      if (draw_done) done_cyc = cyc;
    end
    check($sformatf("v%0d count", idx), npix, v.n);
    check($sformatf("v%0d first_pix_cycle", idx), first_cyc, 2);
    check($sformatf("v%0d consecutive", idx), last_cyc - first_cyc, v.n - 1);
    check($sformatf("v%0d done_after_last", idx), done_cyc, last_cyc + 1);
    check($sformatf("v%0d busy_cycles", idx), busy_cyc, v.n + 1);
    repeat (2) begin
      @(negedge clk);
      check($sformatf("v%0d done_held", idx), {30'd0, draw_done, pix_wr}, 2);
    end
    draw_en = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d done_release", idx), {30'd0, draw_done, busy}, 0);
  endtask

  initial begin
    vecs[0] = '{8'd0, 8'd0, 8'd5, 8'd0, 6, 64'h0000_0504_0302_0100, 64'h0};
    vecs[1] = '{8'd3, 8'd3, 8'd3, 8'd3, 1, 64'h03, 64'h03};
    vecs[2] = '{8'd0, 8'd0, 8'd2, 8'd5, 6, 64'h0000_0202_0101_0000, 64'h0000_0504_0302_0100};
    vecs[3] = '{8'd5, 8'd2, 8'd0, 8'd2, 6, 64'h0000_0001_0203_0405, 64'h0000_0202_0202_0202};
    vecs[4] = '{8'd0, 8'd255, 8'd255, 8'd0, 256, 64'h0, 64'h0};
    vecs[5] = '{8'd2, 8'd5, 8'd0, 8'd0, 6, 64'h0000_0000_0101_0202, 64'h0000_0001_0203_0405};
    vecs[6] = '{8'd0, 8'd0, 8'd3, 8'd1, 4, 64'h0302_0100, 64'h0101_0000};

    #2;
    check("reset outputs", {28'd0, pix_wr, busy, draw_done, |{pix_x, pix_y}}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("idle after reset", {30'd0, busy, pix_wr}, 0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Abort after three pixels of (0,0)->(9,0).
    begin
      int npix, extra, dones;
      npix = 0; extra = 0; dones = 0;
      x0 = 8'd0; y0 = 8'd0; x1 = 8'd9; y1 = 8'd0;
      draw_en = 1'b1;
      for (int cyc = 0; cyc < 20 && draw_en; cyc++) begin
        @(negedge clk);
        if (pix_wr) npix++;
        if (npix == 3) draw_en = 1'b0;
      end
      @(negedge clk);
      check("abort idle next", {30'd0, busy, pix_wr}, 0);
      repeat (12) begin
        @(negedge clk);
        if (pix_wr) extra++;
        if (draw_done) dones++;
      end
      check("abort pixel count", npix + extra, 3);
      check("abort no done", dones, 0);
    end

    // Asynchronous reset pulse in the middle of a line.
    begin
      int npix;
      npix = 0;
      x0 = 8'd0; y0 = 8'd0; x1 = 8'd9; y1 = 8'd0;
      draw_en = 1'b1;
      for (int cyc = 0; cyc < 20 && npix < 2; cyc++) begin
        @(negedge clk);
        if (pix_wr) npix++;
      end
      check("pre-reset pixels", npix, 2);
      #1 n_rst = 1'b0;
      #1;
      check("async reset outputs", {23'd0, pix_wr, busy, draw_done, pix_x, pix_y}, 0);
      draw_en = 1'b0;
      #1 n_rst = 1'b1;
      @(negedge clk);
      check("idle after mid reset", {29'd0, busy, pix_wr, draw_done}, 0);
    end

`ifdef BLA_PIXEL_READY_EN
    // Stall every other cycle on (0,0)->(3,3).
    begin
      int acc, dones;
      logic prev_stall;
      logic [7:0] prev_x, prev_y;
      acc = 0; dones = 0; prev_stall = 1'b0; prev_x = 8'd0; prev_y = 8'd0;
      x0 = 8'd0; y0 = 8'd0; x1 = 8'd3; y1 = 8'd3;
      pix_ready = 1'b0;
      draw_en = 1'b1;
      for (int cyc = 0; cyc < 40 && dones == 0; cyc++) begin
        @(negedge clk);
        if (draw_done) dones++;
        if (prev_stall) begin
          check("stall pix_wr held", pix_wr, 1);
          check("stall pix_x held", pix_x, prev_x);
          check("stall pix_y held", pix_y, prev_y);
        end
        prev_stall = pix_wr && !pix_ready;
        prev_x = pix_x; prev_y = pix_y;
        if (pix_wr && pix_ready) begin
          check("ready pix x", pix_x, acc);
          check("ready pix y", pix_y, acc);
          acc++;
        end
        pix_ready = ~pix_ready;
      end
      check("ready accepted", acc, 4);
      check("ready done", dones, 1);
      draw_en = 1'b0;
      pix_ready = 1'b1;
      @(negedge clk);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
